// File: rtl/spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_cmd_decoder
//
// Parses the byte stream of each SPI chip-select frame into pointer loads,
// VRAM word writes, VRAM word reads and font RAM byte writes, and supplies the
// next byte the SPI target transmits back to the host.
//
// The first byte of a frame is a command: op = cmd[7:6], inc = cmd[3:0].
//   op 00  SETPTR : cmd[4] picks VRAM (0) or font (1) pointer, cmd[5] clears
//                   the sticky flags; two big-endian address bytes follow.
//   op 01  write  : byte pairs form 16-bit words posted at the VRAM pointer.
//   op 10  read   : words are read ahead from VRAM and shifted out hi/lo.
//   op 11  font   : every byte is written to font RAM at the font pointer.
//
// VRAM accesses use a req/ack handshake; only one request is outstanding and
// its address/data/direction stay frozen until the ack cycle.
//
// Ports
//   clk          pixel clock
//   reset_i      asynchronous active-low reset
//   cs_active_i  SPI target selected (synchronous to clk), frames the command
//   rx_strobe_i  one-cycle pulse, rx_byte_i valid
//   rx_byte_i    received byte
//   tx_byte_o    byte the SPI target loads for its next transmit
//   vram_req_o   VRAM access request
//   vram_wr_o    request is a write (valid while vram_req_o is high)
//   vram_addr_o  VRAM word address
//   vram_data_o  VRAM write data
//   vram_ack_i   one-cycle pulse, access performed this cycle
//   vram_data_i  VRAM read data, valid with vram_ack_i
//   font_wr_o    one-cycle font RAM write strobe
//   font_addr_o  font RAM byte address
//   font_data_o  font RAM write data
//   overflow_o   sticky, a VRAM write word was dropped
//   underrun_o   sticky, read data was not ready when the host needed it
// -----------------------------------------------------------------------------
module spi_cmd_decoder #(
  parameter int VRAM_AW = 16,
  parameter int FONT_AW = 13
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               cs_active_i,
  input  logic               rx_strobe_i,
  input  logic [7:0]         rx_byte_i,
  output logic [7:0]         tx_byte_o,
  output logic               vram_req_o,
  output logic               vram_wr_o,
  output logic [VRAM_AW-1:0] vram_addr_o,
  output logic [15:0]        vram_data_o,
  input  logic               vram_ack_i,
  input  logic [15:0]        vram_data_i,
  output logic               font_wr_o,
  output logic [FONT_AW-1:0] font_addr_o,
  output logic [7:0]         font_data_o,
  output logic               overflow_o,
  output logic               underrun_o
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO, FONT, DRAIN
  } state_t;

  typedef enum logic [1:0] {
    OP_SETPTR = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_FONT   = 2'b11
  } op_t;

  localparam logic [7:0] TX_UNDERRUN = 8'hEE;

  state_t               state;
  logic                 cs_q;
  logic [VRAM_AW-1:0]   vram_ptr;
  logic [VRAM_AW-1:0]   rd_addr_q;   // address of a read that had to wait for the slot
  logic [FONT_AW-1:0]   font_ptr;
  logic [3:0]           inc_q;
  logic                 sel_font;
  logic [7:0]           hi_byte;     // address high byte or write-word high byte
  logic [15:0]          rd_buf;
  logic                 rd_want;     // read requested but not yet issued
  logic                 rd_wait;     // read requested and data not yet returned

  // Per-cycle decode
  op_t                  op;
  logic                 cs_rise, cs_fall, rx_ev;
  logic                 slot_free, ack_any, ack_rd;
  logic                 rd_new, rd_issue, rd_ready;
  logic                 wr_post, wr_drop;
  logic                 flag_clr, under_set;
  logic                 overflow_d, underrun_d;
  logic [15:0]          buf_now;
  logic [7:0]           status_d;
  logic [VRAM_AW-1:0]   rd_issue_addr;

  assign op      = op_t'(rx_byte_i[7:6]);
  assign cs_rise = cs_active_i & ~cs_q;
  assign cs_fall = ~cs_active_i & cs_q;
  // Bytes only count inside an open frame and never on a framing edge.
  assign rx_ev   = rx_strobe_i & ~cs_rise & ~cs_fall & (state != IDLE);

  assign ack_any   = vram_ack_i & vram_req_o;
  assign ack_rd    = ack_any & ~vram_wr_o;
  // The ack is processed first, so the slot is reusable in the ack cycle.
  assign slot_free = ~vram_req_o | vram_ack_i;

  // NOTE: every signal written here gets a default first, otherwise paths that
  // skip an assignment would infer a latch.
  always_comb begin
    rd_new   = 1'b0;
    wr_post  = 1'b0;
    wr_drop  = 1'b0;
    flag_clr = 1'b0;
    if (rx_ev) begin
      case (state)
        CMD: begin
          rd_new   = (op == OP_READ);
          flag_clr = (op == OP_SETPTR) && rx_byte_i[5];
        end
        RD_HI:   rd_new = 1'b1;
        WR_LO: begin
          wr_post = slot_free;
          wr_drop = ~slot_free;
        end
        default: ;
      endcase
    end

    // Data for the host is ready if nothing is pending, or if the last pending
    // read is being acked right now.
    rd_ready  = ~rd_wait | (ack_rd & ~rd_want);
    buf_now   = ack_rd ? vram_data_i : rd_buf;
    under_set = rx_ev && (state == RD_HI || state == RD_LO) && !rd_ready;

    rd_issue      = (rd_new | (rd_want & ~cs_fall)) & slot_free & ~wr_post;
    rd_issue_addr = rd_new ? vram_ptr : rd_addr_q;

    overflow_d = flag_clr ? 1'b0 : (overflow_o | wr_drop);
    underrun_d = flag_clr ? 1'b0 : (underrun_o | under_set);
    status_d   = {6'b101000, underrun_d, overflow_d};
  end

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      cs_q        <= 1'b0;
      vram_ptr    <= '0;
      rd_addr_q   <= '0;
      font_ptr    <= '0;
      inc_q       <= '0;
      sel_font    <= 1'b0;
      hi_byte     <= '0;
      rd_buf      <= '0;
      rd_want     <= 1'b0;
      rd_wait     <= 1'b0;
      tx_byte_o   <= 8'hA0;
      vram_req_o  <= 1'b0;
      vram_wr_o   <= 1'b0;
      vram_addr_o <= '0;
      vram_data_o <= '0;
      font_wr_o   <= 1'b0;
      font_addr_o <= '0;
      font_data_o <= '0;
      overflow_o  <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      cs_q       <= cs_active_i;
      font_wr_o  <= 1'b0;
      overflow_o <= overflow_d;
      underrun_o <= underrun_d;

      // VRAM port: the request fields only change when a new request starts.
      if (wr_post) begin
        vram_req_o  <= 1'b1;
        vram_wr_o   <= 1'b1;
        vram_addr_o <= vram_ptr;
        vram_data_o <= {hi_byte, rx_byte_i};
      end else if (rd_issue) begin
        vram_req_o  <= 1'b1;
        vram_wr_o   <= 1'b0;
        vram_addr_o <= rd_issue_addr;
      end else if (ack_any) begin
        vram_req_o  <= 1'b0;
        vram_wr_o   <= 1'b0;
      end

      if (ack_rd) rd_buf <= vram_data_i;

      // A read that cannot go out yet waits for the slot; a frame end drops it.
      rd_want <= (rd_new | rd_want) & ~rd_issue & ~cs_fall;
      if (rd_new) begin
        rd_addr_q <= vram_ptr;
        rd_wait   <= 1'b1;
      end else if (ack_rd && !rd_want) begin
        rd_wait   <= 1'b0;
      end

      // Byte handling
      if (rx_ev) begin
        case (state)
          CMD: begin
            inc_q    <= rx_byte_i[3:0];
            sel_font <= rx_byte_i[4];
            case (op)
              OP_SETPTR: state <= ADDR_HI;
              OP_WRITE:  state <= WR_HI;
              OP_READ: begin
                state    <= RD_HI;
                vram_ptr <= vram_ptr + VRAM_AW'(rx_byte_i[3:0]);
              end
              default:   state <= FONT;
            endcase
          end
          ADDR_HI: begin
            hi_byte <= rx_byte_i;
            state   <= ADDR_LO;
          end
          ADDR_LO: begin
            if (sel_font) font_ptr <= FONT_AW'({hi_byte, rx_byte_i});
            else          vram_ptr <= VRAM_AW'({hi_byte, rx_byte_i});
            state <= DRAIN;
          end
          WR_HI: begin
            hi_byte <= rx_byte_i;
            state   <= WR_LO;
          end
          WR_LO: begin
            // The pointer advances whether the word was posted or dropped.
            vram_ptr <= vram_ptr + VRAM_AW'(inc_q);
            state    <= WR_HI;
          end
          RD_HI: begin
            vram_ptr <= vram_ptr + VRAM_AW'(inc_q);
            state    <= RD_LO;
          end
          RD_LO:   state <= RD_HI;
          FONT: begin
            font_wr_o   <= 1'b1;
            font_addr_o <= font_ptr;
            font_data_o <= rx_byte_i;
            font_ptr    <= font_ptr + FONT_AW'(1);
          end
          default: ;
        endcase
      end

      if (cs_fall)      state <= IDLE;
      else if (cs_rise) state <= CMD;

      // Transmit byte: read data inside a read stream, status byte elsewhere.
      if (rx_ev && state == RD_HI)
        tx_byte_o <= rd_ready ? buf_now[7:0] : TX_UNDERRUN;
      else if (rx_ev && state == RD_LO)
        tx_byte_o <= rd_ready ? buf_now[15:8] : TX_UNDERRUN;
      else if (ack_rd && state == RD_HI && rd_wait && !rd_want && !cs_fall)
        tx_byte_o <= vram_data_i[15:8];
      else if (cs_fall || !(state == RD_HI || state == RD_LO))
        tx_byte_o <= status_d;
    end
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Command decoder between the SPI byte-level target and the video memories. It parses the received byte stream of each chip-select frame into pointer loads, VRAM word writes, VRAM word reads and font RAM byte writes. VRAM accesses go through a req/ack handshake with the blitter slot arbiter, so they only occur in blitter cycles. It supplies the next byte to transmit back to the SPI target. It replaces the ad-hoc echo/test-address logic in the top level.

## Interface
- `VRAM_AW`, 16: VRAM word address width.
- `FONT_AW`, 13: font RAM byte address width.

Ports:
- `clk`  in  1  pixel clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `cs_active_i`  in  1  SPI target selected, already synchronized to `clk`; high for the whole frame.
- `rx_strobe_i`  in  1  one-cycle pulse: `rx_byte_i` is valid.
- `rx_byte_i`  in  8  received byte.
- `tx_byte_o`  out  8  byte the SPI target loads for its next transmit.
- `vram_req_o`  out  1  VRAM access request.
- `vram_wr_o`  out  1  request is a write; valid while `vram_req_o` is high.
- `vram_addr_o`  out  VRAM_AW  access address.
- `vram_data_o`  out  16  write data.
- `vram_ack_i`  in  1  one-cycle pulse: access performed this cycle.
- `vram_data_i`  in  16  read data; valid in the `vram_ack_i` cycle.
- `font_wr_o`  out  1  one-cycle font RAM write strobe.
- `font_addr_o`  out  FONT_AW  font write address.
- `font_data_o`  out  8  font write data.
- `overflow_o`  out  1  sticky: a VRAM write was dropped.
- `underrun_o`  out  1  sticky: read data was not ready when needed.

## Operation
- Frame framing:
  - A rising edge on `cs_active_i` puts the FSM in CMD.
  - A falling edge on `cs_active_i` forces IDLE from any state.
  - Pointers, increment and sticky flags are retained across frames.
- Command byte (first byte of the frame): `op=cmd[7:6]`, `inc=cmd[3:0]`.
  - op 00, SETPTR: `cmd[4]=0` selects the VRAM pointer, `cmd[4]=1` selects the font pointer.
    - ADDR_HI then ADDR_LO load the pointer, big-endian. The font pointer takes the low FONT_AW bits.
    - Further bytes are ignored (DRAIN).
  - op 01, VRAM write stream.
    - WR_HI latches the high byte. WR_LO completes the word and posts a write at the VRAM pointer.
    - After each posted write: pointer += inc, modulo 2^VRAM_AW.
    - Loop WR_HI/WR_LO.
  - op 10, VRAM read stream.
    - Issue a read at the pointer immediately, then pointer += inc.
    - The data latches into a 16-bit read buffer; the buffer is marked valid.
  - op 11, font write stream.
    - Each byte pulses `font_wr_o` with `font_data_o`=byte at the font pointer, then font pointer += 1 (wraps).
    - `inc` is ignored.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO, FONT, DRAIN.
- VRAM handshake:
  - `vram_req_o`, `vram_wr_o`, `vram_addr_o` and `vram_data_o` are held stable from assertion until the `vram_ack_i` cycle.
  - `vram_req_o` drops the cycle after ack.
  - Only one outstanding request at a time.
  - A posted write is never cancelled, including by a frame end; the request stays until acked.
- Write overflow: if WR_LO completes while a request is still outstanding, the word is dropped, `overflow_o` is set, and the pointer still advances.
- Read stream (host clocks dummy bytes):
  - On entry to RD_HI, `tx_byte_o` = buffer[15:8].
  - The next `rx_strobe_i` goes to RD_LO: `tx_byte_o` = buffer[7:0], and a prefetch read is issued at the pointer (pointer += inc).
  - The next strobe returns to RD_HI: the buffer takes the prefetched word.
  - If the prefetch is not acked by that strobe, `tx_byte_o`=8'hEE and `underrun_o` is set; the late data still loads the buffer.
- `tx_byte_o` outside the read stream: status byte {6'b101000, underrun_o, overflow_o}.
- Sticky flags clear when a SETPTR command has `cmd[5]=1`.

## Timing
- Reset values:
  - `tx_byte_o`=8'hA0.
  - `vram_req_o`=0, `vram_wr_o`=0, `vram_addr_o`=0, `vram_data_o`=0.
  - `font_wr_o`=0, `font_addr_o`=0, `font_data_o`=0.
  - `overflow_o`=0, `underrun_o`=0.
  - FSM in IDLE.
- Reset is asynchronous on assert and released synchronously. Reset mid-request drops the request immediately.
- `rx_strobe_i` to `font_wr_o`: 1 cycle (registered).
- WR_LO strobe to `vram_req_o` high: 1 cycle.
- Read ack to `tx_byte_o` update: 1 cycle.
- `tx_byte_o` must be stable at least 1 cycle before the next `rx_strobe_i`. SPI bytes are ≥16 clocks apart.
- Simultaneous `vram_ack_i` and `rx_strobe_i`: the ack is processed first. The outstanding slot frees in that same cycle, so a write completing on that strobe does not overflow.
- `rx_strobe_i` in IDLE is ignored.

## Test plan
- SETPTR: frame 00,12,34 -> VRAM pointer=16'h1234; frame 10,01,00 -> font pointer=13'h0100; no VRAM request.
- Write stream with pointer 16'h1234: frame 41,AB,CD,12,34 -> writes 16'hABCD@16'h1234 and 16'h1234@16'h1235; `vram_req_o` held until each ack.
- Overflow: ack withheld 40 cycles while two words stream -> second word dropped, `overflow_o`=1, pointer advanced by 2; frame 20 clears the flag.
- Read stream with pointer 16'h0010, memory [10]=16'h5A5A and [12]=16'hC3C3: frame 82 then dummy bytes -> `tx_byte_o` sequence 5A,5A,C3,C3; ack held off past the strobe -> 8'hEE and `underrun_o`=1.
- Font stream at font pointer 13'h1FFF: frame C0,11,22 -> font writes 11@1FFF and 22@0000 (wrap).
- `cs_active_i` drops during WR_LO with a request pending, then reset asserted -> request completes on ack before reset; after reset all outputs reach reset values immediately.
